// File: rtl/gs_host_master.sv
// Z80-side host master for the GS sound card: optional argument write, command write,
// status polling and optional response read. GS_HOST_TIMEOUT_EN enables the poll timeout.
module gs_host_master #(
    parameter int unsigned POLL_GAP      = 16,
    parameter int unsigned TIMEOUT_POLLS = 1024
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_code,
    input  logic [7:0] cmd_arg,
    input  logic       cmd_has_arg,
    input  logic       cmd_rd,
    output logic       io_req,
    output logic       io_wr,
    output logic [7:0] io_addr,
    output logic [7:0] io_wdata,
    input  logic [7:0] io_rdata,
    input  logic       io_ack,
    output logic       done,
    output logic       err,
    output logic [7:0] rsp_byte
);

    if (POLL_GAP < 1 || POLL_GAP > 255) begin : g_bad_poll_gap
        $error("POLL_GAP out of range 1..255");
    end
    if (TIMEOUT_POLLS < 1 || TIMEOUT_POLLS > 65535) begin : g_bad_timeout_polls
        $error("TIMEOUT_POLLS out of range 1..65535");
    end

    typedef enum logic [2:0] {
        StIdle, StWrArg, StWrCmd, StCmdPoll, StRspPoll, StRdRsp, StDone
    } state_e;

    localparam logic [7:0] AddrData = 8'hB3;
    localparam logic [7:0] AddrCmd  = 8'hBB;
    localparam logic [7:0] GapLast  = 8'(POLL_GAP - 1);

    state_e     state_q, state_d;
    logic       ready_q, ready_d;
    logic [7:0] code_q, code_d;
    logic [7:0] arg_q, arg_d;
    logic       rd_q, rd_d;
    logic [7:0] rsp_q, rsp_d;
    logic [7:0] gap_q, gap_d;
    logic       req_q, req_d;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       poll_ok;
`ifdef GS_HOST_TIMEOUT_EN
    localparam logic [15:0] PollLast = 16'(TIMEOUT_POLLS - 1);
    logic [15:0] poll_q, poll_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        arg_d   = arg_q;
        rd_d    = rd_q;
        rsp_d   = rsp_q;
        gap_d   = gap_q;
        req_d   = req_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        poll_ok = (state_q == StCmdPoll) ? ~io_rdata[0] : io_rdata[7];
`ifdef GS_HOST_TIMEOUT_EN
        poll_d  = poll_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && ready_q) begin
                    code_d  = cmd_code;
                    arg_d   = cmd_arg;
                    rd_d    = cmd_rd;
                    rsp_d   = 8'h00;
`ifdef GS_HOST_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = cmd_has_arg ? StWrArg : StWrCmd;
                end
            end
            StWrArg, StWrCmd: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = (state_q == StWrArg) ? AddrData : AddrCmd;
                    wdata_d = (state_q == StWrArg) ? arg_q : code_q;
                end else if (io_ack) begin
                    req_d   = 1'b0;
                    gap_d   = 8'd0;
`ifdef GS_HOST_TIMEOUT_EN
                    poll_d  = 16'd0;
`endif
                    state_d = (state_q == StWrArg) ? StWrCmd : StCmdPoll;
                end
            end
            StCmdPoll, StRspPoll: begin
                if (!req_q) begin
                    // Gap counter parks at GapLast while the status read is outstanding.
                    if (gap_q == GapLast) begin
                        req_d   = 1'b1;
                        wr_d    = 1'b0;
                        addr_d  = AddrCmd;
                        wdata_d = 8'h00;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end else if (io_ack) begin
                    req_d = 1'b0;
                    gap_d = 8'd0;
                    if (poll_ok) begin
`ifdef GS_HOST_TIMEOUT_EN
                        poll_d = 16'd0;
`endif
                        if (state_q == StRspPoll) state_d = StRdRsp;
                        else                      state_d = rd_q ? StRspPoll : StDone;
                    end else begin
`ifdef GS_HOST_TIMEOUT_EN
                        poll_d = poll_q + 16'd1;
                        if (poll_q == PollLast) begin
                            err_d   = 1'b1;
                            rsp_d   = 8'h00;
                            state_d = StDone;
                        end
`endif
                    end
                end
            end
            StRdRsp: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    wr_d    = 1'b0;
                    addr_d  = AddrData;
                    wdata_d = 8'h00;
                end else if (io_ack) begin
                    req_d   = 1'b0;
                    rsp_d   = io_rdata;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Registered so cmd_ready stays low in reset and rises on the first edge after it.
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            code_q  <= 8'h00;
            arg_q   <= 8'h00;
            rd_q    <= 1'b0;
            rsp_q   <= 8'h00;
            gap_q   <= 8'd0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            code_q  <= code_d;
            arg_q   <= arg_d;
            rd_q    <= rd_d;
            rsp_q   <= rsp_d;
            gap_q   <= gap_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef GS_HOST_TIMEOUT_EN
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            poll_q <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            poll_q <= poll_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready = ready_q;
    assign io_req    = req_q;
    assign io_wr     = wr_q;
    assign io_addr   = addr_q;
    assign io_wdata  = wdata_q;
    assign done      = (state_q == StDone);
    assign rsp_byte  = rsp_q;

endmodule

// File: tb/tb_gs_host_master.sv
// Bench for gs_host_master: a GS bus responder with random wait states and stray acks, and
// a transaction-level model that derives the expected bus accesses from the status script.
module tb_gs_host_master;

    localparam int unsigned PollGap      = 2;
    localparam int unsigned TimeoutPolls = 4;
    localparam logic [7:0]  AddrData     = 8'hB3;
    localparam logic [7:0]  AddrCmd      = 8'hBB;
`ifdef GS_HOST_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic       clk32 = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_code = 8'h00;
    logic [7:0] cmd_arg = 8'h00;
    logic       cmd_has_arg = 1'b0;
    logic       cmd_rd = 1'b0;
    logic       io_req;
    logic       io_wr;
    logic [7:0] io_addr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata = 8'h00;
    logic       io_ack = 1'b0;
    logic       done;
    logic       err;
    logic [7:0] rsp_byte;

    gs_host_master #(
        .POLL_GAP      (PollGap),
        .TIMEOUT_POLLS (TimeoutPolls)
    ) dut (
        .clk32       (clk32),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_arg     (cmd_arg),
        .cmd_has_arg (cmd_has_arg),
        .cmd_rd      (cmd_rd),
        .io_req      (io_req),
        .io_wr       (io_wr),
        .io_addr     (io_addr),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .io_ack      (io_ack),
        .done        (done),
        .err         (err),
        .rsp_byte    (rsp_byte)
    );

    always #5 clk32 = ~clk32;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    acc_t        seen_q[$];
    acc_t        exp_q[$];
    logic [7:0]  script_q[$];
    logic [7:0]  st_q[$];
    logic [7:0]  stuck_st = 8'h00;
    logic [7:0]  rsp_val = 8'h00;
    bit          hold_rd = 1'b0;
    bit          exp_err;
    logic [7:0]  exp_rsp;
    int unsigned wait_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    // Responder: acks are driven on the falling edge so the master sees them at the next rise.
    always @(negedge clk32) begin
        if (rst) begin
            io_ack = 1'b0;
            wait_cnt = 0;
        end else if (io_ack) begin
            io_ack = 1'b0;
        end else if (io_req && !(hold_rd && !io_wr)) begin
            if (wait_cnt != 0) begin
                wait_cnt--;
            end else begin
                if (io_wr)                 io_rdata = 8'($urandom);
                else if (io_addr == AddrCmd) io_rdata = (st_q.size() > 0) ? st_q.pop_front() : stuck_st;
                else                       io_rdata = rsp_val;
                seen_q.push_back({io_wr, io_addr, io_wr ? io_wdata : io_rdata});
                io_ack = 1'b1;
                wait_cnt = $urandom_range(0, 2);
            end
        end else if (!io_req && $urandom_range(0, 5) == 0) begin
            io_ack = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk the status script phase by phase: command phase ends on bit0=0, response on bit7=1.
    task automatic build_exp(input logic [7:0] code, input logic [7:0] arg, input bit has_arg,
                             input bit rd, input logic [7:0] rspv);
        int         idx = 0;
        int         polls;
        bit         ok;
        logic [7:0] s;
        exp_q.delete();
        exp_err = 1'b0;
        exp_rsp = 8'h00;
        if (has_arg) exp_q.push_back({1'b1, AddrData, arg});
        exp_q.push_back({1'b1, AddrCmd, code});
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1 && !rd) break;
            ok = 1'b0;
            polls = 0;
            while (!ok && !exp_err && polls < 64) begin
                s = (idx < script_q.size()) ? script_q[idx] : stuck_st;
                idx++;
                exp_q.push_back({1'b0, AddrCmd, s});
                polls++;
                ok = (ph == 0) ? !s[0] : s[7];
                if (!ok && ToEn && polls == int'(TimeoutPolls)) exp_err = 1'b1;
            end
            if (exp_err) break;
        end
        if (rd && !exp_err) begin
            exp_q.push_back({1'b0, AddrData, rspv});
            exp_rsp = rspv;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] code, input logic [7:0] arg,
                           input bit has_arg, input bit rd, input logic [7:0] rspv);
        int cyc;
        build_exp(code, arg, has_arg, rd, rspv);
        st_q = script_q;
        seen_q.delete();
        rsp_val = rspv;
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk32);
            cyc++;
        end
        check({tag, "/ready"}, 32'(cmd_ready), 32'd1);
        cmd_code = code;
        cmd_arg = arg;
        cmd_has_arg = has_arg;
        cmd_rd = rd;
        cmd_valid = 1'b1;
        @(negedge clk32);
        cmd_valid = 1'b0;
        check({tag, "/busy"}, 32'(cmd_ready), 32'd0);
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk32);
            cyc++;
        end
        check({tag, "/done"}, 32'(done), 32'd1);
        check({tag, "/err"}, 32'(err), 32'(exp_err));
        if (rd || exp_err) check({tag, "/rsp"}, 32'(rsp_byte), 32'(exp_rsp));
        check({tag, "/n_acc"}, 32'(seen_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < seen_q.size()) check($sformatf("%s/acc%0d", tag, i), 32'(seen_q[i]),
                                         32'(exp_q[i]));
        end
        @(negedge clk32);
        check({tag, "/pulse"}, 32'(done), 32'd0);
        check({tag, "/idle"}, 32'(cmd_ready), 32'd1);
        check({tag, "/err_hold"}, 32'(err), 32'(exp_err));
        if (rd || exp_err) check({tag, "/rsp_hold"}, 32'(rsp_byte), 32'(exp_rsp));
    endtask

    initial begin
        int         cyc;
        int         nb;
        bit         ha;
        bit         rd;
        logic [7:0] v;

        repeat (3) @(negedge clk32);
        check("rst/io_req", 32'(io_req), 32'd0);
        check("rst/io_wr", 32'(io_wr), 32'd0);
        check("rst/io_addr", 32'(io_addr), 32'd0);
        check("rst/io_wdata", 32'(io_wdata), 32'd0);
        check("rst/cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/err", 32'(err), 32'd0);
        check("rst/rsp", 32'(rsp_byte), 32'd0);
        rst = 1'b0;
        #1 check("rel/ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk32);
        check("rel/ready_rise", 32'(cmd_ready), 32'd1);

        script_q = '{8'h01, 8'h01, 8'h00};
        run_cmd("poll3", 8'h23, 8'h00, 1'b0, 1'b0, 8'h00);
        script_q = '{8'h00};
        run_cmd("arg", 8'h10, 8'h5A, 1'b1, 1'b0, 8'h00);
        script_q = '{8'h00, 8'h7E, 8'h80};
        run_cmd("rsp", 8'h33, 8'h00, 1'b0, 1'b1, 8'hC4);
        script_q = '{8'hFF, 8'h81, 8'hFE, 8'h01, 8'hFF};
        run_cmd("ignbits", 8'hA5, 8'h3C, 1'b1, 1'b1, 8'h5A);

        for (int t = 0; t < 25; t++) begin
            ha = 1'($urandom);
            rd = 1'($urandom);
            script_q.delete();
            nb = $urandom_range(0, 2);
            for (int i = 0; i < nb; i++) begin
                v = 8'($urandom) | 8'h01;
                script_q.push_back(v);
            end
            v = 8'($urandom) & 8'hFE;
            script_q.push_back(v);
            if (rd) begin
                nb = $urandom_range(0, 2);
                for (int i = 0; i < nb; i++) begin
                    v = 8'($urandom) & 8'h7F;
                    script_q.push_back(v);
                end
                v = 8'($urandom) | 8'h80;
                script_q.push_back(v);
            end
            run_cmd($sformatf("rnd%0d", t), 8'($urandom), 8'($urandom), ha, rd, 8'($urandom));
        end

`ifdef GS_HOST_TIMEOUT_EN
        script_q.delete();
        stuck_st = 8'h01;
        run_cmd("to_cmd", 8'h44, 8'h00, 1'b0, 1'b0, 8'h99);
        script_q = '{8'h00};
        stuck_st = 8'h00;
        run_cmd("to_rsp", 8'h45, 8'h00, 1'b0, 1'b1, 8'h99);
        script_q = '{8'h00, 8'h80};
        run_cmd("after_to", 8'h46, 8'h00, 1'b0, 1'b1, 8'h77);
`endif

        // Reset while a status read is waiting for its ack.
        script_q.delete();
        st_q.delete();
        stuck_st = 8'h01;
        hold_rd = 1'b1;
        cmd_code = 8'h23;
        cmd_has_arg = 1'b0;
        cmd_rd = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk32);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!(io_req && !io_wr) && cyc < 200) begin
            @(negedge clk32);
            cyc++;
        end
        check("abort/in_read", 32'(io_req && !io_wr), 32'd1);
        rst = 1'b1;
        #1;
        check("abort/io_req", 32'(io_req), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        check("abort/ready", 32'(cmd_ready), 32'd0);
        @(negedge clk32);
        check("abort/done2", 32'(done), 32'd0);
        rst = 1'b0;
        hold_rd = 1'b0;
        stuck_st = 8'h00;
        @(negedge clk32);
        check("abort/ready_rise", 32'(cmd_ready), 32'd1);
        check("abort/no_done", 32'(done), 32'd0);

        script_q = '{8'h01, 8'h00, 8'h80};
        run_cmd("post_abort", 8'h12, 8'h34, 1'b1, 1'b1, 8'hE1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gs_host_master.md
GS_HOST_MASTER -- requirements
Module: gs_host_master

Interface
REQ-001 SHALL have parameter POLL_GAP, default 16: idle clk32 cycles before each status read (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_POLLS, default 1024: maximum status reads per wait phase (range 1..65535).
REQ-003 SHALL have ports, in this order: clk32 in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-004 SHALL have cmd_valid in 1 and cmd_ready out 1, the command handshake.
REQ-005 SHALL have cmd_code in 8, the GS command byte.
REQ-006 SHALL have cmd_arg in 8, the argument byte.
REQ-007 SHALL have cmd_has_arg in 1, which writes cmd_arg to port B3 before the command.
REQ-008 SHALL have cmd_rd in 1, which reads one response byte after the command is taken.
REQ-009 SHALL have io_req out 1, io_wr out 1, io_addr out 8, io_wdata out 8, io_rdata in 8 and io_ack in 1, the Z80-side I/O master bus.
REQ-010 SHALL have done out 1 (one-cycle pulse), err out 1 (timeout, valid with done) and rsp_byte out 8 (valid with done).

Function
REQ-011 SHALL accept a command when cmd_valid and cmd_ready are both 1 on a clk32 edge, and latch all cmd_* fields at that edge.
REQ-012 SHALL assert cmd_ready only in IDLE.
REQ-013 io handshake: io_req, io_wr, io_addr and io_wdata SHALL stay stable from assertion until the cycle io_ack=1; io_req SHALL drop the next cycle; io_rdata SHALL be sampled in the io_ack cycle.
REQ-014 SHALL keep at most one bus access outstanding; io_ack while io_req=0 SHALL be ignored.
REQ-015 FSM states SHALL be: IDLE, WR_ARG, WR_CMD, CMD_POLL, RSP_POLL, RD_RSP, DONE.
REQ-016 IDLE on accept SHALL go to WR_ARG if cmd_has_arg=1, else to WR_CMD.
REQ-017 WR_ARG SHALL write cmd_arg to address 0xB3, then go to WR_CMD.
REQ-018 WR_CMD SHALL write cmd_code to address 0xBB, then go to CMD_POLL.
REQ-019 CMD_POLL SHALL wait POLL_GAP cycles, then read 0xBB; status bit0=1 SHALL repeat the poll.
REQ-020 CMD_POLL on status bit0=0 SHALL go to RSP_POLL if cmd_rd=1, else to DONE.
REQ-021 RSP_POLL SHALL wait POLL_GAP cycles, then read 0xBB; bit7=0 SHALL repeat, bit7=1 SHALL go to RD_RSP.
REQ-022 RD_RSP SHALL read 0xB3, load rsp_byte from io_rdata, then go to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE; rsp_byte and err SHALL hold until the next accept.
REQ-024 The gap counter SHALL be 8 bits and the poll counter 16 bits; both SHALL clear on entry to each poll state.
REQ-025 cmd_valid held across DONE SHALL NOT be accepted before the IDLE cycle, so the minimum spacing between accepts is 1 idle cycle after done.
REQ-026 Status bits other than bit0/bit7 SHALL be ignored.
REQ-027 An io_ack arriving in the same cycle io_req is first asserted SHALL complete the access; zero wait states are legal.

Reset
REQ-028 While rst=1, state SHALL be IDLE and io_req, io_wr, io_addr, io_wdata, cmd_ready, done, err and rsp_byte SHALL all be 0.
REQ-029 cmd_ready SHALL rise on the first clk32 edge after rst falls.
REQ-030 rst asserted mid-transaction SHALL abort immediately: io_req drops asynchronously, with no done pulse.

Configuration
REQ-031 With GS_HOST_TIMEOUT_EN defined: a poll state reaching TIMEOUT_POLLS reads without success SHALL go to DONE with err=1 and rsp_byte=0.
REQ-032 Without GS_HOST_TIMEOUT_EN: polling SHALL continue indefinitely, err SHALL be constant 0, and the poll counter logic SHALL be absent.

Verification
REQ-033 Command 0x23, has_arg=0, rd=0, status reads 0x01,0x01,0x00: exactly the write BB=0x23, then 3 reads of BB, then done=1, err=0.
REQ-034 has_arg=1, arg=0x5A, code=0x10: the first access SHALL be the write B3=0x5A and the second the write BB=0x10.
REQ-035 rd=1, status 0x00 then 0x7E,0x80, B3 returns 0xC4: done with rsp_byte=0xC4, 4 bus accesses after the command write.
REQ-036 GS_HOST_TIMEOUT_EN, TIMEOUT_POLLS=4, status stuck 0x01: exactly 4 BB reads, then done=1, err=1.
REQ-037 rst pulsed during a CMD_POLL read awaiting io_ack: io_req=0 in the same cycle, no done, cmd_ready=1 one cycle after release.
